// File: rtl/cpu_control_pc.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control_pc
//  Purpose  : Instruction decoder and program-counter sequencer for the
//             8-bit CPU. Drives alu select / operand-mux controls and the
//             register-file addresses, resolves beq/bne from the alu ZERO
//             flag, and keeps sticky illegal-opcode and retired counters.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_control_pc #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  PC_STEP      = 4,
  parameter int                  DECODE_DELAY = 1,
  parameter int                  PC_DELAY     = 1,
  parameter int                  CNT_WIDTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          INSTRUCTION,
  input  logic                 ZERO,
  input  logic                 BUSYWAIT,
  output logic [PC_WIDTH-1:0]  PC,
  output logic [2:0]           ALUOP,
  output logic                 WRITEENABLE,
  output logic                 IMMEDIATE_SEL,
  output logic                 NEGATE_SEL,
  output logic [2:0]           WRITEREG,
  output logic [2:0]           READREG1,
  output logic [2:0]           READREG2,
  output logic [7:0]           IMMEDIATE,
  output logic                 ILLEGAL,
  output logic [CNT_WIDTH-1:0] RETIRED
);

  // The decode and PC-update delays exist only to shape behavioural
  // simulation timing; this implementation is zero-delay, so the block below
  // merely consumes the parameters and elaborates to nothing.
  if (DECODE_DELAY < 0 || PC_DELAY < 0) begin : g_delay_params
  end

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_ROR   = 8'h09;

  logic [7:0]          opcode;
  logic                write_dec;
  logic                is_jump;
  logic                is_beq;
  logic                is_bne;
  logic                is_illegal;
  logic                branch_taken;
  logic                advance;
  logic [PC_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] next_pc;
  logic                unused_src1_hi;

  assign opcode    = INSTRUCTION[31:24];
  assign WRITEREG  = INSTRUCTION[18:16];
  assign READREG1  = INSTRUCTION[10:8];
  assign READREG2  = INSTRUCTION[2:0];
  assign IMMEDIATE = INSTRUCTION[7:0];

  // Upper bits of the src1 field carry no meaning for this 8-register file.
  assign unused_src1_hi = &{1'b0, INSTRUCTION[15:11]};

  // Opcode decode into alu controls, write intent and control-flow kind.
  always_comb begin
    ALUOP         = 3'b000;
    IMMEDIATE_SEL = 1'b0;
    NEGATE_SEL    = 1'b0;
    write_dec     = 1'b0;
    is_jump       = 1'b0;
    is_beq        = 1'b0;
    is_bne        = 1'b0;
    is_illegal    = 1'b0;
    case (opcode)
      OP_LOADI: begin ALUOP = 3'b000; IMMEDIATE_SEL = 1'b1; write_dec = 1'b1; end
      OP_MOV:   begin ALUOP = 3'b000; write_dec = 1'b1; end
      OP_ADD:   begin ALUOP = 3'b001; write_dec = 1'b1; end
      OP_SUB:   begin ALUOP = 3'b001; NEGATE_SEL = 1'b1; write_dec = 1'b1; end
      OP_AND:   begin ALUOP = 3'b010; write_dec = 1'b1; end
      OP_OR:    begin ALUOP = 3'b011; write_dec = 1'b1; end
      OP_J:     begin ALUOP = 3'b000; is_jump = 1'b1; end
      OP_BEQ:   begin ALUOP = 3'b001; NEGATE_SEL = 1'b1; is_beq = 1'b1; end
      OP_BNE:   begin ALUOP = 3'b001; NEGATE_SEL = 1'b1; is_bne = 1'b1; end
      OP_ROR:   begin ALUOP = 3'b100; IMMEDIATE_SEL = 1'b1; write_dec = 1'b1; end
      default:  is_illegal = 1'b1;
    endcase
  end

  // Register writes must never land while reset is asserted or memory stalls.
  assign WRITEENABLE = write_dec & ~RESET & ~BUSYWAIT;

  // An instruction completes on any edge that is neither reset nor stalled.
  assign advance = ~RESET & ~BUSYWAIT;

  // Word offset: sign-extend the 8-bit field, then scale to bytes.
  assign offset = PC_WIDTH'($signed(INSTRUCTION[23:16])) << 2;

  assign branch_taken = is_jump | (is_beq & ZERO) | (is_bne & ~ZERO);
  assign seq_pc       = PC + PC_WIDTH'(PC_STEP);
  assign next_pc      = branch_taken ? (seq_pc + offset) : seq_pc;

  // PC, sticky illegal flag and retired counter; reset outranks a stall.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC      <= RESET_PC;
      ILLEGAL <= 1'b0;
      RETIRED <= '0;
    end else if (advance) begin
      PC      <= next_pc;
      RETIRED <= RETIRED + CNT_WIDTH'(1);
      if (is_illegal) begin
        ILLEGAL <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_pc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_control_pc
//  Purpose  : Self-checking bench for cpu_control_pc. Stimulus is scored
//             against a behavioural model; a separate monitor pops expected
//             results from a scoreboard queue and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_control_pc;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        busy;
  logic [31:0] pc;
  logic [2:0]  aluop;
  logic        we;
  logic        imm_sel;
  logic        neg_sel;
  logic [2:0]  wreg;
  logic [2:0]  rreg1;
  logic [2:0]  rreg2;
  logic [7:0]  imm;
  logic        illegal;
  logic [15:0] retired;

  cpu_control_pc dut (
    .CLK           (clk),
    .RESET         (rst),
    .INSTRUCTION   (instr),
    .ZERO          (zero),
    .BUSYWAIT      (busy),
    .PC            (pc),
    .ALUOP         (aluop),
    .WRITEENABLE   (we),
    .IMMEDIATE_SEL (imm_sel),
    .NEGATE_SEL    (neg_sel),
    .WRITEREG      (wreg),
    .READREG1      (rreg1),
    .READREG2      (rreg2),
    .IMMEDIATE     (imm),
    .ILLEGAL       (illegal),
    .RETIRED       (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic [2:0]  aluop;
    logic        imm_sel;
    logic        neg_sel;
    logic        we;
    logic [2:0]  wreg;
    logic [2:0]  rreg1;
    logic [2:0]  rreg2;
    logic [7:0]  imm;
    logic [31:0] pc_after;
    logic        ill_after;
    logic [15:0] ret_after;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Opcode table {aluop[2:0], imm_sel, neg_sel, write} for opcodes 0..9.
  logic [5:0] dec_tab [0:9];
  initial dec_tab = '{6'b000101, 6'b000001, 6'b001001, 6'b001011, 6'b010001,
                      6'b011001, 6'b000000, 6'b001010, 6'b001010, 6'b100101};

  // Architectural state of the reference model.
  logic [31:0] m_pc  = 32'h0;
  logic        m_ill = 1'b0;
  int          m_ret = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Apply one cycle of inputs and push the model's predicted response.
  task automatic step(input logic [31:0] ins, input logic z, input logic b,
                      input logic r);
    exp_t       e;
    int         op;
    int         soff;
    bit         taken;
    logic [5:0] row;
    @(posedge clk);
    #2;
    instr = ins; zero = z; busy = b; rst = r;
    op  = int'(ins[31:24]);
    row = (op <= 9) ? dec_tab[op] : 6'b000000;
    e.ins     = ins;
    e.aluop   = row[5:3];
    e.imm_sel = row[2];
    e.neg_sel = row[1];
    e.we      = row[0] && !r && !b;
    e.wreg    = ins[18:16];
    e.rreg1   = ins[10:8];
    e.rreg2   = ins[2:0];
    e.imm     = ins[7:0];
    if (r) begin
      m_pc = 32'h0; m_ill = 1'b0; m_ret = 0;
    end else if (!b) begin
      taken = (op == 6) || (op == 7 && z) || (op == 8 && !z);
      soff  = int'(ins[23:16]);
      if (soff > 127) soff = soff - 256;
      m_pc  = m_pc + 32'd4 + (taken ? 32'(soff * 4) : 32'd0);
      if (op > 9) m_ill = 1'b1;
      m_ret = (m_ret + 1) % 65536;
    end
    e.pc_after  = m_pc;
    e.ill_after = m_ill;
    e.ret_after = 16'(m_ret);
    sb.push_back(e);
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] d,
                                     input logic [7:0] s1, input logic [7:0] s2);
    return {op, d, s1, s2};
  endfunction

  // Reset, then retire n plain moves so PC lands on 4*n.
  task automatic go_to(input int n);
    step(mk(8'h01, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) step(mk(8'h01, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: decode outputs checked mid-cycle, state checked after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("aluop",   32'(aluop),   32'(e.aluop));
        chk("imm_sel", 32'(imm_sel), 32'(e.imm_sel));
        chk("neg_sel", 32'(neg_sel), 32'(e.neg_sel));
        chk("we",      32'(we),      32'(e.we));
        chk("fields",  {8'h0, 5'(wreg), 3'(rreg1), 5'(rreg2), imm},
                       {8'h0, 5'(e.wreg), 3'(e.rreg1), 5'(e.rreg2), e.imm});
        @(posedge clk);
        #1;
        chk("pc",      pc,             e.pc_after);
        chk("illegal", 32'(illegal),   32'(e.ill_after));
        chk("retired", 32'(retired),   32'(e.ret_after));
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] op;
    instr = 32'h0; zero = 1'b0; busy = 1'b0; rst = 1'b1;

    // Reset from PC 0x20, held for two edges, then two releases.
    go_to(8);
    step(mk(8'h02, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0, 1'b1);
    step(mk(8'h02, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0, 1'b1);
    step(mk(8'h01, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0, 1'b0);
    step(mk(8'h01, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0, 1'b0);

    // Decode sweep over the defined opcodes.
    for (int i = 0; i < 10; i++) step(mk(8'(i), 8'h05, 8'h02, 8'h07), 1'b0, 1'b0, 1'b0);

    // Branches from PC 0x10.
    go_to(4); step(mk(8'h07, 8'h02, 8'h01, 8'h02), 1'b1, 1'b0, 1'b0);
    go_to(4); step(mk(8'h07, 8'h02, 8'h01, 8'h02), 1'b0, 1'b0, 1'b0);
    go_to(4); step(mk(8'h08, 8'hFE, 8'h01, 8'h02), 1'b0, 1'b0, 1'b0);
    go_to(4); step(mk(8'h08, 8'hFE, 8'h01, 8'h02), 1'b1, 1'b0, 1'b0);
    go_to(4); step(mk(8'h06, 8'hFF, 8'h00, 8'h00), 1'b0, 1'b0, 1'b0);

    // Stall during add at PC 0x8, then release; also reset during a stall.
    go_to(2);
    repeat (3) step(mk(8'h02, 8'h03, 8'h01, 8'h02), 1'b0, 1'b1, 1'b0);
    step(mk(8'h02, 8'h03, 8'h01, 8'h02), 1'b0, 1'b0, 1'b0);
    step(mk(8'h02, 8'h03, 8'h01, 8'h02), 1'b0, 1'b1, 1'b0);
    step(mk(8'h02, 8'h03, 8'h01, 8'h02), 1'b0, 1'b1, 1'b1);

    // Illegal opcode at PC 0x4: sticky through legal code, cleared by reset.
    go_to(1);
    step(mk(8'hAA, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0, 1'b0);
    step(mk(8'h02, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0, 1'b0);
    step(mk(8'h07, 8'h01, 8'h02, 8'h03), 1'b1, 1'b0, 1'b0);
    step(mk(8'h00, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0, 1'b1);
    step(mk(8'h00, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0, 1'b0);

    // PC wrap: jump backwards to 0xFFFFFF00, then forward past the top.
    go_to(0);
    step(mk(8'h06, 8'hBF, 8'h00, 8'h00), 1'b0, 1'b0, 1'b0);
    step(mk(8'h06, 8'h7F, 8'h00, 8'h00), 1'b0, 1'b0, 1'b0);

    // Randomized mix of opcodes, flags, stalls and occasional resets.
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      step({op, 24'($urandom)}, 1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0));
    end

    // Retired counter runs to all-ones and wraps to zero.
    go_to(0);
    for (int i = 0; i < 65536; i++)
      step({8'($urandom_range(0, 5)), 24'($urandom)}, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
